pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage image-filter processor.
- Drives the write enables, flushes and bubbles of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Drives the PROHIB_MEM input of the MEM/WB register.
- Resolves load-use hazards, taken-branch flushes, data-memory wait states with timeout, and ALU operand forwarding selects.

---
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch / memory-wait sequencing and forwarding control for the 5-stage pipeline; define HAZ_PERF_CNT_EN to add the stall/flush/error counters
module pipe_hazard_ctrl #(
   parameter int RB           = 4,
   parameter bit R0_HARDWIRED = 1'b1,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef HAZ_PERF_CNT_EN
   input  logic          cnt_clr,
   output logic [15:0]   stall_cnt,
   output logic [15:0]   flush_cnt,
   output logic [7:0]    err_cnt,
`endif
   input  logic [RB-1:0] id_rs1,
   input  logic [RB-1:0] id_rs2,
   input  logic          id_use1,
   input  logic          id_use2,
   input  logic [RB-1:0] ex_rd,
   input  logic          ex_we,
   input  logic          ex_load,
   input  logic [RB-1:0] mem_rd,
   input  logic          mem_we,
   input  logic [RB-1:0] wb_rd,
   input  logic          wb_we,
   input  logic          ex_br_taken,
   input  logic          mem_req,
   input  logic          mem_ack,
   output logic          pc_we,
   output logic          if_id_we,
   output logic          id_ex_we,
   output logic          ex_mem_we,
   output logic          mem_wb_we,
   output logic          flush_if_id,
   output logic          bubble_id_ex,
   output logic          prohib_mem,
   output logic [1:0]    fwd_a,
   output logic [1:0]    fwd_b,
   output logic          mem_err
);
   typedef enum logic {RUN, MEM_WAIT} state_t;
   localparam logic [7:0] TO = 8'(MEM_TIMEOUT);
   state_t     state_q, state_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       luh, abort, freeze;
   function automatic logic match(input logic [RB-1:0] a, input logic [RB-1:0] b);
      return (a == b) && !(R0_HARDWIRED && a == '0);
   endfunction
   function automatic logic [1:0] fwd_sel(input logic [RB-1:0] rs);
      return (mem_we && match(rs, mem_rd)) ? 2'b01 : (wb_we && match(rs, wb_rd)) ? 2'b10 : 2'b00;
   endfunction
   assign luh    = ex_load && ex_we && ((id_use1 && match(id_rs1, ex_rd)) || (id_use2 && match(id_rs2, ex_rd)));
   assign abort  = (state_q == MEM_WAIT) && (wcnt_q == TO) && !mem_ack;
   assign freeze = mem_req && !mem_ack && !abort;
   // state and wait counter; reset discards any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end
   // stay in MEM_WAIT while frozen; wcnt counts cycles spent waiting, anything else returns to RUN
   always_comb begin
      state_d = freeze ? MEM_WAIT : RUN;
      wcnt_d  = (freeze && state_q == MEM_WAIT) ? ((wcnt_q == TO) ? wcnt_q : wcnt_q + 8'd1) : 8'd0;
   end
   // pipeline controls by priority: reset > freeze > abort > branch > load-use > normal
   always_comb begin
      {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b11111;
      flush_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      prohib_mem   = 1'b0;
      mem_err      = 1'b0;
      if (!rst_n) begin
         {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
         flush_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
         prohib_mem   = 1'b1;
      end else if (freeze) begin
         {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 5'b00000;
      end else if (abort) begin
         prohib_mem = 1'b1;
         mem_err    = 1'b1;
      end else if (ex_br_taken) begin
         flush_if_id  = 1'b1;
         bubble_id_ex = 1'b1;
      end else if (luh) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         bubble_id_ex = 1'b1;
      end
   end
   // forwarding selects, independent of stalls; nearest producer wins
   always_comb begin
      fwd_a = rst_n ? fwd_sel(id_rs1) : 2'b00;
      fwd_b = rst_n ? fwd_sel(id_rs2) : 2'b00;
   end
`ifdef HAZ_PERF_CNT_EN
   logic stall_ev, flush_ev;
   assign stall_ev = freeze || (!abort && !ex_br_taken && luh);
   assign flush_ev = !freeze && !abort && ex_br_taken;
   // saturating event counters with synchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
         err_cnt   <= 8'd0;
      end else if (cnt_clr) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
         err_cnt   <= 8'd0;
      end else begin
         stall_cnt <= stall_cnt + 16'((stall_ev && stall_cnt != 16'hffff) ? 1 : 0);
         flush_cnt <= flush_cnt + 16'((flush_ev && flush_cnt != 16'hffff) ? 1 : 0);
         err_cnt   <= err_cnt + 8'((abort && err_cnt != 8'hff) ? 1 : 0);
      end
   end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stalls, flushes, memory timeout and forwarding
module tb_pipe_hazard_ctrl;
   localparam logic [15:0] C_NORM   = 16'b1_1111_0000;
   localparam logic [15:0] C_RST    = 16'b0_0000_1110;
   localparam logic [15:0] C_FRZ    = 16'b0_0000_0000;
   localparam logic [15:0] C_LUH    = 16'b0_0111_0100;
   localparam logic [15:0] C_BR     = 16'b1_1111_1100;
   localparam logic [15:0] C_ABORT  = 16'b1_1111_0011;
   logic       clk = 1'b0, rst_n;
   logic [3:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use1, id_use2, ex_we, ex_load, mem_we, wb_we, ex_br_taken, mem_req, mem_ack;
   logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, bubble_id_ex, prohib_mem, mem_err;
   logic [1:0] fwd_a, fwd_b;
   logic [15:0] ctl;
   int n_cmp = 0, n_err = 0;
   pipe_hazard_ctrl #(.RB(4), .R0_HARDWIRED(1'b1), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load), .mem_rd(mem_rd), .mem_we(mem_we),
      .wb_rd(wb_rd), .wb_we(wb_we), .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
      .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex), .prohib_mem(prohib_mem),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err));
   always #5 clk = ~clk;
   assign ctl = {7'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, bubble_id_ex, prohib_mem, mem_err};
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask
   task automatic idle();
      {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {id_use1, id_use2, ex_we, ex_load, mem_we, wb_we, ex_br_taken, mem_req, mem_ack} = '0;
   endtask
   // check controls mid-cycle, then advance to just after the next rising edge
   task automatic cyc(input string tag, input logic [15:0] exp);
      @(negedge clk);
      check(tag, ctl, exp);
      @(posedge clk);
      #1;
   endtask
   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_ctl", ctl, C_RST);
      check("reset_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc("post_reset", C_NORM);
      // load-use on rs1
      ex_load = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
      cyc("luh_rs1", C_LUH);
      ex_load = 0;
      cyc("luh_after", C_NORM);
      // load-use on rs2
      ex_load = 1; id_use1 = 0; id_rs2 = 5; id_use2 = 1;
      cyc("luh_rs2", C_LUH);
      // operand not used
      id_use2 = 0;
      cyc("luh_unused", C_NORM);
      // r0 never hazards
      ex_rd = 0; id_rs1 = 0; id_use1 = 1;
      cyc("luh_r0", C_NORM);
      idle();
      // memory wait with ack after three cycles
      mem_req = 1;
      for (int i = 0; i < 3; i++) cyc($sformatf("wait_frz%0d", i), C_FRZ);
      mem_ack = 1;
      cyc("wait_ack", C_NORM);
      idle();
      cyc("wait_done", C_NORM);
      // timeout: five freeze cycles then abort
      mem_req = 1;
      for (int i = 0; i < 5; i++) cyc($sformatf("to_frz%0d", i), C_FRZ);
      cyc("to_abort", C_ABORT);
      mem_req = 0;
      cyc("to_after", C_NORM);
      // zero-stall access
      mem_req = 1; mem_ack = 1;
      cyc("ack_same", C_NORM);
      idle();
      // branch with simultaneous load-use
      ex_br_taken = 1; ex_load = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_use1 = 1;
      cyc("br_luh", C_BR);
      idle();
      cyc("br_after", C_NORM);
      // branch during freeze is deferred to the ack cycle
      mem_req = 1; ex_br_taken = 1;
      cyc("br_frz0", C_FRZ);
      cyc("br_frz1", C_FRZ);
      mem_ack = 1;
      cyc("br_ack", C_BR);
      idle();
      // reset mid-wait discards the wait count
      mem_req = 1;
      cyc("rstw_frz0", C_FRZ);
      cyc("rstw_frz1", C_FRZ);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rstw_reset", ctl, C_RST);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc($sformatf("rstw_frz%0d", i + 2), C_FRZ);
      cyc("rstw_abort", C_ABORT);
      idle();
      // forwarding priority
      mem_rd = 7; wb_rd = 7; mem_we = 1; wb_we = 1; id_rs1 = 7; id_rs2 = 3;
      #1;
      check("fwd_a_mem", {14'd0, fwd_a}, 16'd1);
      check("fwd_b_none", {14'd0, fwd_b}, 16'd0);
      mem_we = 0;
      #1;
      check("fwd_a_wb", {14'd0, fwd_a}, 16'd2);
      wb_we = 0;
      #1;
      check("fwd_a_rf", {14'd0, fwd_a}, 16'd0);
      mem_we = 1; id_rs2 = 7;
      #1;
      check("fwd_b_mem", {14'd0, fwd_b}, 16'd1);
      mem_rd = 0; wb_rd = 0; wb_we = 1; id_rs1 = 0;
      #1;
      check("fwd_a_r0", {14'd0, fwd_a}, 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
